// File: rtl/wishbone_pkg.sv
// Shared types and defaults for the Wishbone N-way peripheral interconnect.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wishbone_pkg;

    localparam int DEF_ADR_W  = 8;
    localparam int DEF_PADR_W = 4;
    localparam int DEF_DAT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for a master request
        ST_BUSY = 2'd1,   // request forwarded to one peripheral
        ST_RESP = 2'd2    // single-cycle ack/err termination
    } wb_state_e;

    // Width needed to hold a peripheral index; never narrower than one bit.
    function automatic int idx_width(input int peri);
        return (peri > 1) ? $clog2(peri) : 1;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Busy-cycle watchdog: counts cycles while run is high, flags the last allowed one.
// Latency: expired is combinational from the registered count (no extra cycle).
// Backpressure: none; clear has priority over run.
//
// Ports: clk, rst_n (async, active-low), clear (restart count at 0),
//        run (count this cycle), expired (count reached TIMEOUT-1 while running).
module wb_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + 8'd1;
        end
    end

    // The count equals (busy cycle number - 1), so this fires on the TIMEOUT-th busy cycle.
    assign expired = run && (count == LAST);

endmodule

// File: rtl/wb_interconnect_n.sv
// Single-master to PERI-peripheral Wishbone decoder with unmapped-address and timeout errors.
// Latency: p_stb one cycle after m_stb; m_ack/m_err one cycle after p_ack/timeout (unmapped: cycle 1).
// Backpressure: one transaction in flight; master holds m_stb until termination, dropping it aborts.
//
// Ports: clk, rst_n (async, active-low); master side m_stb/m_we/m_adr/m_dat_w in,
//        m_dat_r/m_ack/m_err out; peripheral side p_stb (one-hot), p_we/p_adr/p_dat_w
//        broadcast out, p_dat_r (slice per peripheral) and p_ack in.
module wb_interconnect_n
    import wishbone_pkg::*;
#(
    parameter int PERI    = 4,
    parameter int ADR_W   = DEF_ADR_W,
    parameter int PADR_W  = DEF_PADR_W,
    parameter int DAT_W   = DEF_DAT_W,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m_stb,
    input  logic                  m_we,
    input  logic [ADR_W-1:0]      m_adr,
    input  logic [DAT_W-1:0]      m_dat_w,
    output logic [DAT_W-1:0]      m_dat_r,
    output logic                  m_ack,
    output logic                  m_err,
    output logic [PERI-1:0]       p_stb,
    output logic                  p_we,
    output logic [PADR_W-1:0]     p_adr,
    output logic [DAT_W-1:0]      p_dat_w,
    input  logic [PERI*DAT_W-1:0] p_dat_r,
    input  logic [PERI-1:0]       p_ack
);

    localparam int IDX_W = idx_width(PERI);
    localparam int FLD_W = ADR_W - PADR_W;
    localparam logic [FLD_W:0] PERI_LIM = (FLD_W + 1)'(PERI);

    wb_state_e        state;
    logic [IDX_W-1:0] idx_q;

    // Decode of the incoming request; the extra MSB lets PERI=2**FLD_W compare cleanly.
    logic [FLD_W-1:0] req_fld;
    logic [IDX_W-1:0] req_idx;
    logic             req_mapped;

    assign req_fld    = m_adr[ADR_W-1:PADR_W];
    assign req_idx    = IDX_W'(req_fld);
    assign req_mapped = ({1'b0, req_fld} < PERI_LIM);

    // Only the selected peripheral's ack and data lane are ever looked at.
    logic             sel_ack;
    logic [DAT_W-1:0] sel_dat;

    assign sel_ack = p_ack[idx_q];
    assign sel_dat = p_dat_r[int'(idx_q)*DAT_W +: DAT_W];

    logic wd_clear;
    logic wd_run;
    logic wd_expired;

    assign wd_clear = (state == ST_IDLE) && m_stb && req_mapped;
    assign wd_run   = (state == ST_BUSY);

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .run     (wd_run),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx_q   <= '0;
            p_stb   <= '0;
            p_we    <= 1'b0;
            p_adr   <= '0;
            p_dat_w <= '0;
            m_ack   <= 1'b0;
            m_err   <= 1'b0;
            m_dat_r <= '0;
        end else begin
            // Terminations are single-cycle pulses owned by RESP.
            m_ack <= 1'b0;
            m_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (m_stb) begin
                        idx_q   <= req_idx;
                        p_we    <= m_we;
                        p_adr   <= m_adr[PADR_W-1:0];
                        p_dat_w <= m_dat_w;
                        if (req_mapped) begin
                            p_stb <= PERI'(1) << req_idx;
                            state <= ST_BUSY;
                        end else begin
                            m_err   <= 1'b1;
                            m_dat_r <= '0;
                            state   <= ST_RESP;
                        end
                    end
                end

                ST_BUSY: begin
                    // Abort beats ack; ack beats a simultaneous timeout.
                    if (!m_stb) begin
                        p_stb <= '0;
                        state <= ST_IDLE;
                    end else if (sel_ack) begin
                        p_stb   <= '0;
                        m_ack   <= 1'b1;
                        m_dat_r <= sel_dat;
                        state   <= ST_RESP;
                    end else if (wd_expired) begin
                        p_stb   <= '0;
                        m_err   <= 1'b1;
                        m_dat_r <= '0;
                        state   <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    state <= ST_IDLE;
                end

                default: begin
                    p_stb <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_interconnect_n.sv
// Self-checking bench for wb_interconnect_n: directed scenarios plus randomized accesses.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_wb_interconnect_n;

    localparam int PERI    = 4;
    localparam int ADR_W   = 8;
    localparam int PADR_W  = 4;
    localparam int DAT_W   = 8;
    localparam int TIMEOUT = 15;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  m_stb = 1'b0;
    logic                  m_we = 1'b0;
    logic [ADR_W-1:0]      m_adr = '0;
    logic [DAT_W-1:0]      m_dat_w = '0;
    logic [DAT_W-1:0]      m_dat_r;
    logic                  m_ack;
    logic                  m_err;
    logic [PERI-1:0]       p_stb;
    logic                  p_we;
    logic [PADR_W-1:0]     p_adr;
    logic [DAT_W-1:0]      p_dat_w;
    logic [PERI*DAT_W-1:0] p_dat_r = '0;
    logic [PERI-1:0]       p_ack = '0;

    int checks   = 0;
    int failures = 0;
    logic [DAT_W-1:0] last_dat = '0;

    always #5 clk = ~clk;

    wb_interconnect_n #(
        .PERI    (PERI),
        .ADR_W   (ADR_W),
        .PADR_W  (PADR_W),
        .DAT_W   (DAT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_adr   (m_adr),
        .m_dat_w (m_dat_w),
        .m_dat_r (m_dat_r),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .p_stb   (p_stb),
        .p_we    (p_we),
        .p_adr   (p_adr),
        .p_dat_w (p_dat_w),
        .p_dat_r (p_dat_r),
        .p_ack   (p_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One master access. Called right after a negedge; that cycle is cycle 0.
    // d: the peripheral raises ack d cycles after p_stb first appears (cycle 1+d).
    task automatic access(input logic [7:0] adr, input logic we, input logic [7:0] wdat,
                          input int d, input logic [7:0] rdat);
        int              idx;
        bit              mapped;
        logic [PERI-1:0] sel;
        int              resp;
        bit              is_ack;
        logic [7:0]      ack_dat;

        idx     = int'(adr[7:4]);
        mapped  = (idx < PERI);
        sel     = mapped ? PERI'(1 << idx) : '0;
        ack_dat = 8'h00;
        if (!mapped) begin
            resp = 1; is_ack = 0;
        end else if (d <= TIMEOUT - 1) begin
            resp = d + 2; is_ack = 1;
        end else begin
            resp = TIMEOUT + 1; is_ack = 0;
        end

        m_stb = 1'b1; m_we = we; m_adr = adr; m_dat_w = wdat; p_ack = '0;

        for (int c = 1; c <= resp + 1; c++) begin
            @(negedge clk);
            if (c == resp) last_dat = is_ack ? ack_dat : 8'h00;
            chk("p_stb", 32'(p_stb), (mapped && c < resp) ? 32'(sel) : 32'd0);
            chk("m_ack", 32'(m_ack), 32'(c == resp && is_ack));
            chk("m_err", 32'(m_err), 32'(c == resp && !is_ack));
            chk("m_dat_r", 32'(m_dat_r), 32'(last_dat));
            if (c == 1) begin
                chk("p_we", 32'(p_we), 32'(we));
                chk("p_adr", 32'(p_adr), 32'(adr[3:0]));
                chk("p_dat_w", 32'(p_dat_w), 32'(wdat));
            end
            // Inputs for cycle c: random lanes, noise acks on unselected peripherals.
            p_dat_r = $urandom;
            p_ack   = PERI'($urandom) & ~sel;
            if (mapped && c == 1 + d) begin
                p_ack = p_ack | sel;
                p_dat_r[idx*DAT_W +: DAT_W] = rdat;
                ack_dat = rdat;
            end
        end
        m_stb = 1'b0;
        p_ack = '0;
    endtask

    initial begin
        int       d;
        int       ridx;
        bit [7:0] radr;

        repeat (3) @(negedge clk);
        chk("rst_p_stb", 32'(p_stb), 32'd0);
        chk("rst_p_we", 32'(p_we), 32'd0);
        chk("rst_p_adr", 32'(p_adr), 32'd0);
        chk("rst_p_dat_w", 32'(p_dat_w), 32'd0);
        chk("rst_m_ack", 32'(m_ack), 32'd0);
        chk("rst_m_err", 32'(m_err), 32'd0);
        chk("rst_m_dat_r", 32'(m_dat_r), 32'd0);

        // First access starts in the same cycle reset is released.
        rst_n = 1'b1;
        access(8'h21, 1'b0, 8'h00, 3, 8'hA5);
        access(8'h3F, 1'b1, 8'h5A, 0, 8'hC3);
        access(8'h70, 1'b0, 8'h11, 0, 8'h00);
        access(8'h05, 1'b0, 8'h00, 99, 8'h00);
        // Ack on the last busy cycle wins over the timeout; one cycle later is too late.
        access(8'h14, 1'b0, 8'h00, TIMEOUT - 1, 8'h6E);
        access(8'h24, 1'b0, 8'h00, TIMEOUT, 8'h99);

        // Abort: m_stb dropped in busy cycle 2, followed by a late ack.
        m_stb = 1'b1; m_we = 1'b0; m_adr = 8'h12; p_ack = '0;
        @(negedge clk);
        chk("abort_p_stb_c1", 32'(p_stb), 32'h2);
        @(negedge clk);
        chk("abort_p_stb_c2", 32'(p_stb), 32'h2);
        m_stb = 1'b0;
        @(negedge clk);
        chk("abort_p_stb_c3", 32'(p_stb), 32'd0);
        chk("abort_m_ack_c3", 32'(m_ack), 32'd0);
        chk("abort_m_err_c3", 32'(m_err), 32'd0);
        p_ack = 4'b0010;
        @(negedge clk);
        chk("abort_p_stb_c4", 32'(p_stb), 32'd0);
        chk("abort_m_ack_c4", 32'(m_ack), 32'd0);
        chk("abort_m_err_c4", 32'(m_err), 32'd0);
        p_ack = '0;

        // Reset mid-busy on a second access.
        m_stb = 1'b1; m_we = 1'b1; m_adr = 8'h35; m_dat_w = 8'h77;
        @(negedge clk);
        chk("rb_p_stb", 32'(p_stb), 32'h8);
        chk("rb_p_we", 32'(p_we), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rb_p_stb_async", 32'(p_stb), 32'd0);
        chk("rb_p_we_async", 32'(p_we), 32'd0);
        chk("rb_p_adr_async", 32'(p_adr), 32'd0);
        chk("rb_p_dat_w_async", 32'(p_dat_w), 32'd0);
        chk("rb_m_dat_r_async", 32'(m_dat_r), 32'd0);
        chk("rb_m_ack_async", 32'(m_ack), 32'd0);
        chk("rb_m_err_async", 32'(m_err), 32'd0);
        m_stb = 1'b0;
        last_dat = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_p_stb", 32'(p_stb), 32'd0);
            chk("post_rst_m_ack", 32'(m_ack), 32'd0);
            chk("post_rst_m_err", 32'(m_err), 32'd0);
        end
        access(8'h1C, 1'b0, 8'h00, 1, 8'h3C);

        // Randomized back-to-back accesses.
        for (int n = 0; n < 40; n++) begin
            ridx = $urandom_range(0, 5);
            radr = {4'(ridx), 4'($urandom)};
            if ($urandom_range(0, 3) == 0) d = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
            else d = $urandom_range(0, 4);
            access(radr, 1'($urandom), 8'($urandom), d, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_interconnect_n.md
WB_INTERCONNECT_N -- requirements
Module: wb_interconnect_n

Interface
REQ-001 Parameters SHALL be:
- PERI, 4: number of peripherals, 1..16.
- ADR_W, 8: master address width.
- PADR_W, 4: peripheral-local address width, < ADR_W.
- DAT_W, 8: data width.
- TIMEOUT, 15: maximum cycles to wait for a peripheral ack, 2..255.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: the block's single clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- m_stb, in, 1: master strobe.
- m_we, in, 1: master write enable.
- m_adr, in, ADR_W: master address.
- m_dat_w, in, DAT_W: master write data.
- m_dat_r, out, DAT_W: read data to master.
- m_ack, out, 1: normal termination.
- m_err, out, 1: error termination (unmapped address or timeout).
- p_stb, out, PERI: per-peripheral strobe.
- p_we, out, 1: write enable broadcast to all peripherals.
- p_adr, out, PADR_W: local address broadcast to all peripherals.
- p_dat_w, out, DAT_W: write data broadcast to all peripherals.
- p_dat_r, in, PERI*DAT_W: peripheral read data; slice i belongs to peripheral i.
- p_ack, in, PERI: per-peripheral ack.

Function
REQ-003 Peripheral index idx SHALL be m_adr[ADR_W-1:PADR_W]; idx >= PERI SHALL be unmapped.
REQ-004 The FSM SHALL have three states:
- IDLE: waiting for a request.
- BUSY: request forwarded to a peripheral.
- RESP: one-cycle termination.
REQ-005 In IDLE with m_stb=1, the block SHALL latch idx, m_we, m_adr[PADR_W-1:0] and m_dat_w:
- mapped idx: go to BUSY;
- unmapped idx: go to RESP with the error flag set.
REQ-006 In BUSY, p_stb[idx] SHALL be 1, all other p_stb bits 0, and p_we/p_adr/p_dat_w SHALL present the latched values.
REQ-007 Outside BUSY, all p_stb bits SHALL be 0; p_we, p_adr and p_dat_w SHALL hold their last values.
REQ-008 In BUSY, p_ack[idx]=1 SHALL register p_dat_r slice idx into m_dat_r and go to RESP with the ack flag set.
- p_ack bits of non-selected peripherals SHALL be ignored.
REQ-009 A BUSY cycle counter SHALL clear on entry to BUSY and increment each BUSY cycle.
- If it reaches TIMEOUT-1 with no ack, the next state SHALL be RESP with the error flag set and m_dat_r=0.
REQ-010 An ack in the same cycle as the timeout SHALL win: ack response, no error.
REQ-011 In RESP, exactly one of m_ack/m_err SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-012 m_ack and m_err SHALL be 0 in IDLE and BUSY.
REQ-013 Latency for a mapped access:
- m_stb sampled at cycle 0, p_stb high from cycle 1;
- peripheral ack at cycle k gives m_ack at cycle k+1.
REQ-014 Latency for an unmapped access: m_err SHALL be high at cycle 1.
REQ-015 m_stb deasserted while in BUSY SHALL abort:
- next state IDLE, no m_ack/m_err pulse;
- a late p_ack SHALL be ignored.
REQ-016 m_stb still high in IDLE following RESP SHALL start a new transaction; back-to-back transactions are legal.
REQ-017 m_dat_r SHALL hold its value until the next ack or error.
- Read data SHALL be captured on writes as well; its value on a write is don't-care to the master.

Reset
REQ-018 rst_n=0 SHALL asynchronously force:
- state IDLE, counter 0, latched idx 0;
- p_stb 0, p_we 0, p_adr 0, p_dat_w 0;
- m_ack 0, m_err 0, m_dat_r 0.
REQ-019 Reset asserted mid-transaction SHALL drop p_stb within the same cycle and produce no termination pulse after release.
REQ-020 The first transaction SHALL be accepted on the first clk edge with rst_n=1.

Structure
REQ-021 Package wishbone_pkg SHALL hold:
- the FSM state enum;
- default width constants (ADR_W, PADR_W, DAT_W);
- a helper function computing the index width, $clog2(PERI) minimum 1.
REQ-022 The timeout counter SHALL be a sub-module wb_watchdog with ports clk, rst_n, clear, run, expired, and parameter TIMEOUT.

Verification
REQ-023 Directed scenarios (defaults unless stated):
- Read, m_adr=0x21, peripheral 2 acks 3 cycles after p_stb with 0xA5 -> p_stb=4'b0100, p_adr=1, m_ack one cycle, m_dat_r=0xA5, at cycle 5.
- Write, m_adr=0x3F, m_dat_w=0x5A, peripheral 3 acks immediately -> p_we=1, p_dat_w=0x5A, p_adr=0xF, m_ack at cycle 2.
- Unmapped address, m_adr=0x70 -> no p_stb, m_err at cycle 1, m_dat_r=0.
- Peripheral 0 never acks, TIMEOUT=15 -> p_stb[0] high 15 cycles, m_err at cycle 16, then IDLE.
- Abort then reset: m_stb dropped at BUSY cycle 2, then rst_n pulsed low mid-BUSY of a second access -> no m_ack/m_err, p_stb=0 immediately, all outputs 0; a following access to peripheral 1 completes normally.
